// File: rtl/dibit_pkg.sv
// Shared definitions for the 2-bit symbol link transmitter.
// Optional feature macro: DIBIT_TX_PARITY_EN (adds a fifth marker/parity symbol).
package dibit_pkg;

   // Transmit FSM states; StPar is only reachable with the parity build.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StPar  = 2'd2
   } dibit_state_e;

   localparam int unsigned DIBIT_SYMS_PER_BYTE = 4;
   localparam logic [1:0]  DIBIT_IDLE_SYM      = 2'b00;
   localparam logic        DIBIT_PAR_MARKER    = 1'b1;

   // Index of the final data symbol of a byte.
   localparam logic [1:0]  DIBIT_LAST_IDX      = 2'(DIBIT_SYMS_PER_BYTE - 1);

   // Trailing symbol: marker bit in the MSB, even-parity bit of the byte in the LSB.
   function automatic logic [1:0] dibit_par_sym(input logic [7:0] b);
      return {DIBIT_PAR_MARKER, ^b};
   endfunction

endpackage

// File: rtl/dibit_sym_timer.sv
// Symbol-period timer: counts 0..SYM_DIV-1 while run is high and flags the first
// and last cycle of each symbol. Held at zero while run is low.
module dibit_sym_timer #(
   parameter int unsigned SYM_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic run,
   output logic first,
   output logic last
);

   localparam int unsigned CntW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SYM_DIV - 1);

   logic [CntW-1:0] div_cnt_q;
   logic [CntW-1:0] div_cnt_d;

   // Decode the symbol boundaries from the current count.
   always_comb begin
      first = (div_cnt_q == '0);
      last  = (div_cnt_q == CntMax);
   end

   // Next count: clear when stopped, wrap at the end of a symbol.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!run || last) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/dibit_tx.sv
// Byte-to-dibit transmitter: accepts bytes over valid/ready and serialises each
// one as four 2-bit symbols, each held SYM_DIV cycles with a strobe on its first
// cycle. Build macro DIBIT_TX_PARITY_EN appends a {marker, even-parity} symbol.
module dibit_tx #(
   parameter int unsigned SYM_DIV   = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] in_dat,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [1:0] out_dat,
   output logic       out_strobe,
   output logic       busy
);

   import dibit_pkg::*;

   dibit_state_e state_q, state_d;
   logic [1:0]   sym_idx_q, sym_idx_d;
   logic [7:0]   shift_q, shift_d;
`ifdef DIBIT_TX_PARITY_EN
   logic [1:0]   par_sym_q, par_sym_d;
`endif

   logic       run;
   logic       sym_first;
   logic       sym_last;
   logic       final_last;
   logic       accept;
   logic [7:0] shift_next;

   assign run = (state_q != StIdle);

   dibit_sym_timer #(
      .SYM_DIV (SYM_DIV)
   ) u_timer (
      .CLK   (CLK),
      .RST   (RST),
      .run   (run),
      .first (sym_first),
      .last  (sym_last)
   );

   // Handshake: ready in idle or on the very last cycle of the byte's final symbol.
   always_comb begin
`ifdef DIBIT_TX_PARITY_EN
      final_last = sym_last && (state_q == StPar);
`else
      final_last = sym_last && (state_q == StSend) && (sym_idx_q == DIBIT_LAST_IDX);
`endif
      in_ready = !RST && ((state_q == StIdle) || final_last);
      accept   = in_valid && in_ready;
   end

   // Shift the next symbol into the output position of the shift register.
   always_comb begin
      if (MSB_FIRST) begin
         shift_next = {shift_q[5:0], 2'b00};
      end else begin
         shift_next = {2'b00, shift_q[7:2]};
      end
   end

   // Next-state logic for the transmit FSM and its datapath.
   always_comb begin
      state_d   = state_q;
      sym_idx_d = sym_idx_q;
      shift_d   = shift_q;
`ifdef DIBIT_TX_PARITY_EN
      par_sym_d = par_sym_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d   = StSend;
               sym_idx_d = '0;
               shift_d   = in_dat;
`ifdef DIBIT_TX_PARITY_EN
               par_sym_d = dibit_par_sym(in_dat);
`endif
            end
         end
         StSend: begin
            if (sym_last) begin
               if (sym_idx_q == DIBIT_LAST_IDX) begin
`ifdef DIBIT_TX_PARITY_EN
                  state_d   = StPar;
                  sym_idx_d = '0;
`else
                  // A new byte accepted here starts with no idle gap.
                  if (accept) begin
                     state_d   = StSend;
                     sym_idx_d = '0;
                     shift_d   = in_dat;
                  end else begin
                     state_d   = StIdle;
                     sym_idx_d = '0;
                  end
`endif
               end else begin
                  sym_idx_d = sym_idx_q + 2'd1;
                  shift_d   = shift_next;
               end
            end
         end
`ifdef DIBIT_TX_PARITY_EN
         StPar: begin
            if (sym_last) begin
               if (accept) begin
                  state_d   = StSend;
                  sym_idx_d = '0;
                  shift_d   = in_dat;
                  par_sym_d = dibit_par_sym(in_dat);
               end else begin
                  state_d   = StIdle;
                  sym_idx_d = '0;
               end
            end
         end
`endif
         default: begin
            state_d   = StIdle;
            sym_idx_d = '0;
         end
      endcase
   end

   // Link outputs, decoded from registered state only so they change just after a rising edge.
   always_comb begin
      out_dat    = DIBIT_IDLE_SYM;
      busy       = (state_q != StIdle);
      out_strobe = busy && sym_first;
      if (state_q == StSend) begin
         out_dat = MSB_FIRST ? shift_q[7:6] : shift_q[1:0];
      end
`ifdef DIBIT_TX_PARITY_EN
      if (state_q == StPar) begin
         out_dat = par_sym_q;
      end
`endif
   end

   // State registers with synchronous reset; reset abandons any byte in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         sym_idx_q <= '0;
         shift_q   <= '0;
`ifdef DIBIT_TX_PARITY_EN
         par_sym_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sym_idx_q <= sym_idx_d;
         shift_q   <= shift_d;
`ifdef DIBIT_TX_PARITY_EN
         par_sym_q <= par_sym_d;
`endif
      end
   end

endmodule

// File: tb/tb_dibit_tx.sv
// Directed self-checking bench for dibit_tx; four instances cover the
// SYM_DIV / MSB_FIRST combinations. Honors DIBIT_TX_PARITY_EN when defined.
module tb_dibit_tx;

`ifdef DIBIT_TX_PARITY_EN
   localparam int NSYM = 5;
`else
   localparam int NSYM = 4;
`endif

   logic       CLK = 1'b0;
   logic [3:0] rst;
   logic [3:0] vld;
   logic [7:0] dat [4];
   logic [1:0] od  [4];
   logic [3:0] strb;
   logic [3:0] bsy;
   logic [3:0] rdy;

   int n_total = 0;
   int n_pass  = 0;

   always #5 CLK = ~CLK;

   dibit_tx #(.SYM_DIV(4), .MSB_FIRST(1'b1)) u0 (
      .CLK(CLK), .RST(rst[0]), .in_dat(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .out_dat(od[0]), .out_strobe(strb[0]), .busy(bsy[0])
   );
   dibit_tx #(.SYM_DIV(4), .MSB_FIRST(1'b0)) u1 (
      .CLK(CLK), .RST(rst[1]), .in_dat(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .out_dat(od[1]), .out_strobe(strb[1]), .busy(bsy[1])
   );
   dibit_tx #(.SYM_DIV(2), .MSB_FIRST(1'b1)) u2 (
      .CLK(CLK), .RST(rst[2]), .in_dat(dat[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
      .out_dat(od[2]), .out_strobe(strb[2]), .busy(bsy[2])
   );
   dibit_tx #(.SYM_DIV(1), .MSB_FIRST(1'b1)) u3 (
      .CLK(CLK), .RST(rst[3]), .in_dat(dat[3]), .in_valid(vld[3]), .in_ready(rdy[3]),
      .out_dat(od[3]), .out_strobe(strb[3]), .busy(bsy[3])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance one cycle; samples then sit 1 time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Checks one whole byte starting in its first cycle. syms holds symbols 0..3 in
   // emission order, symbol 0 in [7:6].
   task automatic check_byte(input int u, input int div, input logic [7:0] syms,
                             input logic [1:0] par_sym, input string tag);
      logic [1:0] e;
      for (int s = 0; s < NSYM; s++) begin
         for (int c = 0; c < div; c++) begin
            e = (s < 4) ? syms[7-2*s -: 2] : par_sym;
            check({tag, "_dat"},    32'(od[u]),   32'(e));
            check({tag, "_strobe"}, 32'(strb[u]), 32'(c == 0));
            check({tag, "_busy"},   32'(bsy[u]),  32'd1);
            check({tag, "_ready"},  32'(rdy[u]),  32'((s == NSYM - 1) && (c == div - 1)));
            tick();
         end
      end
   endtask

   task automatic check_idle(input int u, input string tag);
      check({tag, "_dat"},   32'(od[u]),  32'd0);
      check({tag, "_busy"},  32'(bsy[u]), 32'd0);
      check({tag, "_ready"}, 32'(rdy[u]), 32'd1);
   endtask

   initial begin
      rst = 4'hF;
      vld = 4'h0;
      for (int i = 0; i < 4; i++) dat[i] = 8'h00;
      tick();
      tick();
      check("rst_ready_forced", 32'(rdy[0]),  32'd0);
      check("rst_dat",          32'(od[0]),   32'd0);
      check("rst_strobe",       32'(strb[0]), 32'd0);
      check("rst_busy",         32'(bsy[0]),  32'd0);
      rst = 4'h0;
      #1;
      for (int i = 0; i < 4; i++) check_idle(i, "post_rst");

      // Basic byte, MSB first: 10 11 01 00.
      dat[0] = 8'hB4; vld[0] = 1'b1;
      tick();
      vld[0] = 1'b0;
      check_byte(0, 4, 8'hB4, 2'b10, "basic");
      check_idle(0, "basic_end");

      // LSB first: 00 01 11 10.
      dat[1] = 8'hB4; vld[1] = 1'b1;
      tick();
      vld[1] = 1'b0;
      check_byte(1, 4, 8'h1E, 2'b10, "lsb");
      check_idle(1, "lsb_end");

      // Back-to-back with valid held high: 1B then E4, no gap.
      dat[2] = 8'h1B; vld[2] = 1'b1;
      tick();
      dat[2] = 8'hE4;
      check_byte(2, 2, 8'h1B, 2'b10, "b2b0");
      vld[2] = 1'b0;
      check_byte(2, 2, 8'hE4, 2'b10, "b2b1");
      check_idle(2, "b2b_end");

      // One symbol per cycle: strobe stays high.
      dat[3] = 8'hFF; vld[3] = 1'b1;
      tick();
      vld[3] = 1'b0;
      check_byte(3, 1, 8'hFF, 2'b10, "div1");
      check_idle(3, "div1_end");

      // Reset during symbol 2 abandons the byte.
      dat[0] = 8'hB4; vld[0] = 1'b1;
      tick();
      vld[0] = 1'b0;
      repeat (8) tick();
      check("mid_sym2_dat",    32'(od[0]),   32'b01);
      check("mid_sym2_strobe", 32'(strb[0]), 32'd1);
      rst[0] = 1'b1;
      tick();
      check("mid_rst_dat",   32'(od[0]),  32'd0);
      check("mid_rst_busy",  32'(bsy[0]), 32'd0);
      check("mid_rst_ready", 32'(rdy[0]), 32'd0);
      rst[0] = 1'b0;
      #1;
      check("mid_rel_ready", 32'(rdy[0]), 32'd1);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("mid_quiet_dat",    32'(od[0]),   32'd0);
         check("mid_quiet_strobe", 32'(strb[0]), 32'd0);
         check("mid_quiet_busy",   32'(bsy[0]),  32'd0);
      end

`ifdef DIBIT_TX_PARITY_EN
      // Parity symbol: 07 -> 11, 03 -> 10.
      dat[0] = 8'h07; vld[0] = 1'b1;
      tick();
      vld[0] = 1'b0;
      check_byte(0, 4, 8'h07, 2'b11, "par07");
      check_idle(0, "par07_end");
      dat[0] = 8'h03; vld[0] = 1'b1;
      tick();
      vld[0] = 1'b0;
      check_byte(0, 4, 8'h03, 2'b10, "par03");
      check_idle(0, "par03_end");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dibit_tx.md
# dibit_tx

Transmit end of the 2-bit symbol link whose receive side is a negedge-capture 2-bit register. Accepts bytes over a valid/ready handshake and emits each as four 2-bit symbols (optionally five with parity) on `out_dat`. Each symbol is held for a programmable number of `CLK` cycles, with a one-cycle strobe at every symbol start. Sits between the byte-producing control logic and the 2-bit link wires.

## Interface
- `SYM_DIV`, default 4: CLK cycles each symbol is held; legal range 1..256.
- `MSB_FIRST`, default 1: 1 sends bits [7:6] first; 0 sends bits [1:0] first.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `in_dat`  in  8  byte to send; sampled only on the accept edge.
- `in_valid`  in  1  `in_dat` is valid.
- `in_ready`  out  1  block can accept on this edge.
- `out_dat`  out  2  current link symbol; 2'b00 when idle.
- `out_strobe`  out  1  high for exactly the first cycle of each symbol.
- `busy`  out  1  high while any symbol of a byte is on the link.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`; the byte is latched into an internal shift register.
- States:
  - IDLE: `in_ready`=1, `out_dat`=00, `busy`=0.
  - SEND: symbols 0..3 go out in order set by `MSB_FIRST`.
  - PAR: only with the parity macro.
- Transitions:
  - IDLE→SEND on accept.
  - SEND→SEND on the last cycle of symbol 3 if a new accept occurs; the new byte's symbol 0 follows with no gap.
  - SEND→IDLE on the last cycle of symbol 3 with no accept.
  - With parity, symbol 3 leads to PAR instead, and the same rules apply at the end of PAR.
- `in_ready` = IDLE, or (last cycle of the final symbol); it is combinational from state/counters and forced 0 while `RST`=1.
- Divide counter `div_cnt` runs 0..SYM_DIV-1 and wraps. The symbol index advances when `div_cnt`=SYM_DIV-1. SYM_DIV=1 gives one symbol per cycle, with `out_strobe` constantly high during SEND.
- `in_dat`/`in_valid` changes outside the accept edge have no effect.
- Reset mid-byte: the byte is abandoned and no further symbols are emitted. On the first cycle after reset, outputs take their reset values.
- Reset values (registered outputs): `out_dat`=00, `out_strobe`=0, `busy`=0, state IDLE, `div_cnt`=0, symbol index 0.

## Timing
- Accept on edge k: `out_dat`=symbol 0 and `out_strobe`=1 during cycle k+1 (latency 1).
- Each symbol is stable for exactly SYM_DIV cycles. Its value changes only after a rising edge, so it is stable at every falling edge within the symbol, including the strobe cycle.
- Byte duration is 4·SYM_DIV cycles, or 5·SYM_DIV with parity. Back-to-back throughput is one byte per byte duration.
- `busy` rises in cycle k+1 and falls in the first cycle after the final symbol when no follow-on accept occurred.

## Configuration
- `DIBIT_TX_PARITY_EN` defined:
  - A fifth symbol {1'b1, ^byte} (marker bit + even-parity bit) follows symbol 3.
  - The PAR state exists.
  - `in_ready` opens in the last PAR cycle.
- Undefined: four symbols per byte; no PAR state in the netlist.

## Structure
- Shared package `dibit_pkg`:
  - state typedef (IDLE, SEND, PAR);
  - `DIBIT_SYMS_PER_BYTE`=4;
  - `DIBIT_IDLE_SYM`=2'b00;
  - parity marker constant.
- One sub-module `dibit_sym_timer`:
  - parameter SYM_DIV; inputs `CLK`, `RST`, `run`;
  - outputs `first` (`div_cnt`==0) and `last` (`div_cnt`==SYM_DIV-1);
  - counter clears when `run`=0.

## Test plan
- Basic byte: SYM_DIV=4, MSB_FIRST=1, send 8'hB4 → `out_dat` shows 10, 11, 01, 00, each 4 cycles; 4 strobes 4 cycles apart; first strobe in the cycle after accept; `busy` high for 16 cycles.
- Bit order: MSB_FIRST=0, send 8'hB4 → symbols 00, 01, 11, 10.
- Back-to-back: `in_valid` held high with 8'h1B then 8'hE4, SYM_DIV=2 → 8 contiguous symbols 00 01 10 11 11 10 01 00 with no idle cycle; `in_ready` high only in cycle 8 of the first byte.
- SYM_DIV=1: send 8'hFF → `out_dat`=11 for 4 consecutive cycles with `out_strobe`=1 in all 4; then `out_dat`=00.
- Reset mid-byte: assert `RST` one cycle during symbol 2 of 8'hB4 → next cycle `out_dat`=00, `busy`=0, `in_ready`=1 after `RST` drops; no further symbols.
- Parity (macro on): send 8'h07 → symbols 00, 00, 01, 11, then 11 (marker 1, parity 1); send 8'h03 → fifth symbol 10.
